// File: rtl/imm_encoder.sv
// Immediate encoder: packs a signed immediate into RISC-V I/S/B fields and queues the word
// with its write address in a 2-entry FIFO. Optional macro IMM_ENC_STICKY_ERR_EN adds ErrSticky.
module imm_encoder #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Clear,
   input  logic              InValid,
   output logic              InReady,
   input  logic [1:0]        ImmSrc,
   input  logic [31:0]       ImmIn,
   input  logic [31:0]       BaseInstr,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [31:0]       InstrOut,
   output logic [ADDR_W-1:0] WrAddr,
   output logic              RangeErr
`ifdef IMM_ENC_STICKY_ERR_EN
   ,
   output logic              ErrSticky
`endif
);

   typedef enum logic [1:0] {
      IMM_I   = 2'b00,
      IMM_S   = 2'b01,
      IMM_B   = 2'b10,
      IMM_RSV = 2'b11
   } imm_kind_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } entry_t;

   imm_kind_t kind;
   logic      fits12;
   logic      fits13;
   entry_t    enc;

   entry_t    slot_q [2];
   logic      wr_ptr_q;
   logic      rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic      in_ready_q;
   logic [ADDR_W-1:0] addr_q;
   entry_t    head;
   logic      push;
   logic      pop;

   assign kind = imm_kind_t'(ImmSrc);

   // Sign-extension check: all bits above the field's sign bit must equal it.
   assign fits12 = (&ImmIn[31:11]) | ~(|ImmIn[31:11]);
   assign fits13 = (&ImmIn[31:12]) | ~(|ImmIn[31:12]);

   always_comb begin
      enc.instr = BaseInstr;
      enc.err   = 1'b1;
      unique case (kind)
         IMM_I: begin
            enc.instr = {ImmIn[11:0], BaseInstr[19:0]};
            enc.err   = ~fits12;
         end
         IMM_S: begin
            enc.instr = {ImmIn[11:5], BaseInstr[24:12], ImmIn[4:0], BaseInstr[6:0]};
            enc.err   = ~fits12;
         end
         IMM_B: begin
            enc.instr = {ImmIn[12], ImmIn[10:5], BaseInstr[24:12], ImmIn[4:1], ImmIn[11],
                         BaseInstr[6:0]};
            enc.err   = ~fits13 | ImmIn[0];
         end
         IMM_RSV: begin
            enc.instr = BaseInstr;
            enc.err   = 1'b1;
         end
      endcase
   end

   assign head     = slot_q[rd_ptr_q];
   assign OutValid = (count_q != 2'd0);
   assign InstrOut = OutValid ? head.instr : '0;
   assign RangeErr = OutValid & head.err;
   assign InReady  = in_ready_q;
   assign WrAddr   = addr_q;

   assign push = InValid & in_ready_q & ~Clear;
   assign pop  = OutValid & OutReady & ~Clear;

   always_comb begin
      count_d = count_q;
      if (Clear) begin
         count_d = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // InReady is registered from the next count so OutReady never reaches it combinationally.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         addr_q     <= BASE_ADDR;
         for (int unsigned i = 0; i < 2; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         count_q    <= count_d;
         in_ready_q <= (count_d != 2'd2);
         if (Clear) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            addr_q   <= BASE_ADDR;
         end else begin
            if (push) begin
               slot_q[wr_ptr_q] <= enc;
               wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_q <= ~rd_ptr_q;
               addr_q   <= addr_q + ADDR_W'(4);
            end
         end
      end
   end

`ifdef IMM_ENC_STICKY_ERR_EN
   logic sticky_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sticky_q <= 1'b0;
      end else if (Clear) begin
         sticky_q <= 1'b0;
      end else if (pop && head.err) begin
         sticky_q <= 1'b1;
      end
   end

   assign ErrSticky = sticky_q;
`endif

endmodule
